// File: rtl/outbox.sv
// outbox: show-ahead output FIFO carrying R to an external consumer.
// Optional occupancy port oCount is built when OUTBOX_COUNT_EN is defined.
module outbox #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [7:0]            iR,
    input  logic                  wO,
    output logic                  oFull,
    output logic [7:0]            oData,
    output logic                  oValid,
    input  logic                  iReady,
`ifdef OUTBOX_COUNT_EN
    output logic [DEPTH_LOG2:0]   oCount,
`endif
    output logic                  oOvf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2:0]   wp;
    logic [DEPTH_LOG2:0]   rp;
    logic                  ovf;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;

    assign empty = (wp == rp);
    assign full  = (wp[DEPTH_LOG2-1:0] == rp[DEPTH_LOG2-1:0])
                && (wp[DEPTH_LOG2] != rp[DEPTH_LOG2]);
    assign push  = wO && !full;
    assign pop   = !empty && iReady;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp  <= '0;
            rp  <= '0;
            ovf <= 1'b0;
        end else begin
            if (push)
                wp <= wp + PTR_ONE;
            if (pop)
                rp <= rp + PTR_ONE;
            if (wO && full)
                ovf <= 1'b1;
        end
    end

    // Storage is never cleared; reset makes old entries unreachable.
    always_ff @(posedge clk) begin
        if (rstn && push)
            mem[wp[DEPTH_LOG2-1:0]] <= iR;
    end

    assign oValid = !empty;
    assign oFull  = full;
    assign oOvf   = ovf;
    assign oData  = empty ? 8'h00 : mem[rp[DEPTH_LOG2-1:0]];

`ifdef OUTBOX_COUNT_EN
    assign oCount = wp - rp;
`endif

endmodule

// File: tb/tb_outbox.sv
// tb_outbox: queue-model scoreboard for outbox, directed plus random.
// Monitor compares DUT outputs every falling edge against the model.
module tb_outbox;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic           clk = 1'b0;
    logic           rstn;
    logic [7:0]     iR;
    logic           wO;
    logic           iReady;
    logic           oFull;
    logic [7:0]     oData;
    logic           oValid;
    logic           oOvf;
`ifdef OUTBOX_COUNT_EN
    logic [DL2:0]   oCount;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [7:0] mq[$];
    bit         movf = 1'b0;
    logic [7:0] cons_q[$];

    outbox #(.DEPTH_LOG2(DL2)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .iR     (iR),
        .wO     (wO),
        .oFull  (oFull),
        .oData  (oData),
        .oValid (oValid),
        .iReady (iReady),
`ifdef OUTBOX_COUNT_EN
        .oCount (oCount),
`endif
        .oOvf   (oOvf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a bounded queue updated from pre-edge state.
    always @(posedge clk) begin
        bit full_now;
        bit empty_now;
        if (!rstn) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            full_now  = (mq.size() == DEPTH);
            empty_now = (mq.size() == 0);
            if (wO && full_now)
                movf = 1'b1;
            if (!empty_now && iReady)
                void'(mq.pop_front());
            if (wO && !full_now)
                mq.push_back(iR);
        end
    end

    always @(negedge clk) begin
        int exp_data;
        if (chk_en) begin
            exp_data = (mq.size() != 0) ? int'(mq[0]) : 0;
            check("valid", int'(oValid), int'(mq.size() != 0));
            check("data", int'(oData), exp_data);
            check("full", int'(oFull), int'(mq.size() == DEPTH));
            check("ovf", int'(oOvf), int'(movf));
`ifdef OUTBOX_COUNT_EN
            check("count", int'(oCount), mq.size());
`endif
            if (rstn && oValid && iReady)
                cons_q.push_back(oData);
        end
    end

    task automatic cyc(input bit w, input logic [7:0] d, input bit r);
        wO     = w;
        iR     = d;
        iReady = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int occ;
        bit w;
        bit r;
        int wp_pct;
        int rp_pct;

        rstn   = 1'b0;
        wO     = 1'b1;
        iR     = 8'h05;
        iReady = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid", int'(oValid), 0);
        check("rst_data", int'(oData), 0);
        check("rst_ovf", int'(oOvf), 0);
        check("rst_full", int'(oFull), 0);
        rstn = 1'b1;

        cyc(1'b1, 8'h03, 1'b0);
        check("single_valid", int'(oValid), 1);
        check("single_data", int'(oData), 8'h03);
        cyc(1'b0, 8'h00, 1'b1);
        check("single_pop_valid", int'(oValid), 0);
        check("single_pop_data", int'(oData), 0);

        for (int i = 1; i <= 16; i++)
            cyc(1'b1, 8'(i), 1'b0);
        check("fill_full", int'(oFull), 1);
`ifdef OUTBOX_COUNT_EN
        check("fill_count", int'(oCount), 16);
`endif
        cyc(1'b1, 8'h63, 1'b0);
        check("fill_ovf", int'(oOvf), 1);
        for (int i = 1; i <= 16; i++) begin
            check("drain_data", int'(oData), i);
            cyc(1'b0, 8'h00, 1'b1);
        end
        check("drain_empty", int'(oValid), 0);
        check("drain_ovf_sticky", int'(oOvf), 1);

        cyc(1'b1, 8'hFF, 1'b0);
        check("sim_head", int'(oData), 8'hFF);
        cyc(1'b1, 8'h80, 1'b1);
        check("sim_data", int'(oData), 8'h80);
        check("sim_valid", int'(oValid), 1);
`ifdef OUTBOX_COUNT_EN
        check("sim_count", int'(oCount), 1);
`endif
        cyc(1'b0, 8'h00, 1'b1);

        rstn = 1'b0;
        cyc(1'b0, 8'h00, 1'b0);
        rstn = 1'b1;
        check("rst2_ovf", int'(oOvf), 0);

        cons_q.delete();
        cyc(1'b1, 8'd0, 1'b0);
        occ = 1;
        for (int v = 1; v < 40; v++) begin
            r = (occ >= 2);
            cyc(1'b1, 8'(v), r);
            if (!r)
                occ++;
        end
        while (occ > 0) begin
            cyc(1'b0, 8'h00, 1'b1);
            occ--;
        end
        check("wrap_len", cons_q.size(), 40);
        for (int i = 0; i < 40 && i < cons_q.size(); i++)
            check("wrap_order", int'(cons_q[i]), i);
        check("wrap_ovf", int'(oOvf), 0);

        for (int i = 0; i < 5; i++)
            cyc(1'b1, 8'(8'h20 + i), 1'b0);
        rstn = 1'b0;
        cyc(1'b1, 8'h55, 1'b1);
        rstn = 1'b1;
        check("midrst_valid", int'(oValid), 0);
`ifdef OUTBOX_COUNT_EN
        check("midrst_count", int'(oCount), 0);
`endif
        cyc(1'b1, 8'h07, 1'b0);
        check("midrst_head", int'(oData), 8'h07);
        cyc(1'b0, 8'h00, 1'b1);
        check("midrst_alone", int'(oValid), 0);

        for (int blk = 0; blk < 6; blk++) begin
            wp_pct = (blk % 2 == 0) ? 75 : 35;
            rp_pct = (blk % 2 == 0) ? 35 : 75;
            for (int c = 0; c < 400; c++) begin
                w = ($urandom_range(99) < wp_pct);
                r = ($urandom_range(99) < rp_pct);
                rstn = ($urandom_range(299) != 0);
                cyc(w, 8'($urandom), r);
            end
            rstn = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
